// File: rtl/multi_cycle_cpu.sv
// Purpose: 16-bit-instruction multi-cycle CPU (FETCH/DECODE/EXEC/MEM/WB/HALT), 16 x DATA_W register file.
// Latency: ALU/CMP/jump 4 cycles, LD/ST 5 cycles with zero-wait acks; each ack wait cycle adds one.
// Backpressure: req held with address/data stable until ack sampled high; define MULTI_CYCLE_CPU_RETIRE_CNT_EN for retired_cnt.
module multi_cycle_cpu #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              zf,
    output logic              cf,
    output logic              adder_carry_out,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instruction,
    output logic [31:0]       retired_cnt
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0, OP_AND = 4'h1, OP_ADDI = 4'h2, OP_ANDI = 4'h3,
                           OP_LD   = 4'h4, OP_ST  = 4'h5, OP_CMP  = 4'h6, OP_JMP  = 4'h7,
                           OP_JE   = 4'h8, OP_JB  = 4'h9, OP_JA   = 4'hA, OP_HALT = 4'hF;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         instr_q;
    logic [DATA_W-1:0]   rf_q [16];
    logic [DATA_W-1:0]   res_q;
    logic                zf_q, cf_q, carry_q;

    logic [3:0]          opcode, rd, rs1, rs2;
    logic [DATA_W-1:0]   op_a, op_b, imm, alu_b, alu_res;
    logic [DATA_W:0]     sum;
    logic                is_imm, is_mem, writes_reg, jump_taken;

    assign opcode = instr_q[15:12];
    assign rd     = instr_q[11:8];
    assign rs1    = instr_q[7:4];
    assign rs2    = instr_q[3:0];
    assign op_a   = rf_q[rs1];
    assign op_b   = rf_q[rs2];
    assign imm    = DATA_W'($signed(instr_q[3:0]));
    assign is_imm = (opcode == OP_ADDI) || (opcode == OP_ANDI);
    assign alu_b  = is_imm ? imm : op_b;
    assign sum    = {1'b0, op_a} + {1'b0, alu_b};
    assign alu_res = (opcode == OP_AND || opcode == OP_ANDI) ? (op_a & alu_b) : sum[DATA_W-1:0];
    assign is_mem = (opcode == OP_LD) || (opcode == OP_ST);
    assign writes_reg = (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_ADDI) ||
                        (opcode == OP_ANDI) || (opcode == OP_LD);
    assign jump_taken = (opcode == OP_JMP) ||
                        (opcode == OP_JE && zf_q) ||
                        (opcode == OP_JB && cf_q) ||
                        (opcode == OP_JA && !zf_q && !cf_q);

    // Next-state and next-pc; pc only moves in WB, HALT keeps its own address.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = is_mem ? S_MEM : S_WB;
            S_MEM:    if (dmem_ack) state_d = S_WB;
            S_WB: begin
                if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    pc_d    = jump_taken ? ADDR_W'(instr_q[11:0]) : pc_q + ADDR_W'(1);
                end
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Datapath registers: instruction latch, ALU/load result, flags, pc.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '0;
            instr_q <= '0;
            res_q   <= '0;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (state_q == S_FETCH && imem_ack) instr_q <= imem_rdata;
            if (state_q == S_EXEC) begin
                res_q <= alu_res;
                if (opcode == OP_ADD || opcode == OP_ADDI) carry_q <= sum[DATA_W];
                if (opcode == OP_CMP) begin
                    zf_q <= (op_a == op_b);
                    cf_q <= (op_a < op_b);
                end
            end
            if (state_q == S_MEM && dmem_ack && opcode == OP_LD) res_q <= dmem_rdata;
        end
    end

    // Register file, written only in WB so sources always see the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else if (state_q == S_WB && writes_reg) begin
            rf_q[rd] <= res_q;
        end
    end

`ifdef MULTI_CYCLE_CPU_RETIRE_CNT_EN
    logic [31:0] retired_q;

    // Retirement counter: one per WB, HALT included, wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              retired_q <= '0;
        else if (state_q == S_WB)  retired_q <= retired_q + 32'd1;
    end
    assign retired_cnt = retired_q;
`else
    assign retired_cnt = '0;
`endif

    // reset_n gates req so it drops the instant reset asserts even though state resets to FETCH.
    assign imem_req        = (state_q == S_FETCH) && reset_n;
    assign imem_addr       = pc_q;
    assign dmem_req        = (state_q == S_MEM);
    assign dmem_we         = dmem_req && (opcode == OP_ST);
    assign dmem_addr       = ADDR_W'(instr_q[7:0]);
    assign dmem_wdata      = rf_q[rd];
    assign zf              = zf_q;
    assign cf              = cf_q;
    assign adder_carry_out = carry_q;
    assign halted          = (state_q == S_HALT);
    assign pc              = pc_q;
    assign instruction     = instr_q;

endmodule

// File: tb/tb_multi_cycle_cpu.sv
module tb_multi_cycle_cpu;
    localparam int DW = 16;
    localparam int AW = 12;
`ifdef MULTI_CYCLE_CPU_RETIRE_CNT_EN
    localparam int EXP_RET = 4;
`else
    localparam int EXP_RET = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          imem_req, imem_ack;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_rdata;
    logic          dmem_req, dmem_we, dmem_ack;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic          zf, cf, adder_carry_out, halted;
    logic [AW-1:0] pc;
    logic [15:0]   instruction;
    logic [31:0]   retired_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0]   imem [0:4095];
    logic [DW-1:0] dmem [0:4095];
    int            imem_wait = 0;
    int            dmem_wait = 0;
    int            icnt, dcnt, wr_count, st_cycles;
    bit            d_unstable, we_bad, prev_dreq;
    logic [AW-1:0] d_addr0;
    logic [DW-1:0] d_wdata0;
    logic          d_we0;
    logic [AW-1:0] fetch_log [$];

    always #5 clk = ~clk;

    multi_cycle_cpu #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .zf(zf), .cf(cf), .adder_carry_out(adder_carry_out), .halted(halted),
        .pc(pc), .instruction(instruction), .retired_cnt(retired_cnt)
    );

    // Memory responders: decide ack on the falling edge, DUT samples it on the next rising edge.
    initial begin
        imem_ack = 0; dmem_ack = 0; imem_rdata = 0; dmem_rdata = 0;
        icnt = 0; dcnt = 0; prev_dreq = 0;
        for (int i = 0; i < 4096; i++) dmem[i] = '0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (icnt >= imem_wait) begin
                    imem_ack = 1; imem_rdata = imem[imem_addr]; fetch_log.push_back(imem_addr);
                end else begin
                    imem_ack = 0; icnt++;
                end
            end else begin
                imem_ack = 0; icnt = 0;
            end
            if (dmem_we && !dmem_req) we_bad = 1;
            if (dmem_req) begin
                if (!prev_dreq) begin
                    d_addr0 = dmem_addr; d_wdata0 = dmem_wdata; d_we0 = dmem_we;
                end else if (dmem_addr !== d_addr0 || dmem_wdata !== d_wdata0 || dmem_we !== d_we0) begin
                    d_unstable = 1;
                end
                if (dmem_we) st_cycles++;
                if (dcnt >= dmem_wait) begin
                    dmem_ack = 1; dmem_rdata = dmem[dmem_addr];
                    if (dmem_we) begin dmem[dmem_addr] = dmem_wdata; wr_count++; end
                end else begin
                    dmem_ack = 0; dcnt++;
                end
            end else begin
                dmem_ack = 0; dcnt = 0;
            end
            prev_dreq = dmem_req;
        end
    end

    task automatic fill_halt();
        for (int i = 0; i < 4096; i++) imem[i] = 16'hF000;
    endtask

    // Reset, clear monitors, release just after a rising edge.
    task automatic start();
        reset_n = 0;
        repeat (2) @(posedge clk);
        wr_count = 0; st_cycles = 0; d_unstable = 0; we_bad = 0;
        fetch_log.delete();
        @(posedge clk); #1 reset_n = 1;
    endtask

    task automatic run_to_halt(input int budget, output int cyc);
        cyc = 0;
        while (!halted && cyc < budget) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        @(posedge clk); #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req: got %b want 0", imem_req); end
        checks++; if ({dmem_req, dmem_we} !== 2'b00) begin errors++; $display("FAIL rst_dmem: got %b want 00", {dmem_req, dmem_we}); end
        checks++; if (pc !== 12'h000 || instruction !== 16'h0000) begin errors++; $display("FAIL rst_pc_instr: got %h/%h want 000/0000", pc, instruction); end
        checks++; if ({zf, cf, adder_carry_out, halted} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want 0000", {zf, cf, adder_carry_out, halted}); end
        checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL rst_retired: got %0d want 0", retired_cnt); end
    endtask

    task automatic test_basic();
        int cyc;
        bit req_seen;
        fill_halt();
        imem[0] = 16'h2105; imem[1] = 16'h2203; imem[2] = 16'h0312; imem[3] = 16'hF000;
        start();
        run_to_halt(100, cyc);
        checks++; if (halted !== 1'b1 || cyc != 16) begin errors++; $display("FAIL basic_halt_cycle: got halted=%b cycle=%0d want 1 at 16", halted, cyc); end
        checks++; if (dut.rf_q[3] !== 16'd8) begin errors++; $display("FAIL basic_r3: got %h want 0008", dut.rf_q[3]); end
        checks++; if (dut.rf_q[1] !== 16'd5 || dut.rf_q[2] !== 16'd3) begin errors++; $display("FAIL basic_r1r2: got %h/%h want 0005/0003", dut.rf_q[1], dut.rf_q[2]); end
        checks++; if (retired_cnt !== 32'(EXP_RET)) begin errors++; $display("FAIL basic_retired: got %0d want %0d", retired_cnt, EXP_RET); end
        checks++; if (pc !== 12'h003) begin errors++; $display("FAIL basic_halt_pc: got %h want 003", pc); end
        req_seen = 0;
        repeat (6) begin @(posedge clk); #1; if (imem_req || dmem_req) req_seen = 1; end
        checks++; if (req_seen !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL basic_halt_quiet: got req_seen=%b halted=%b want 0/1", req_seen, halted); end
    endtask

    task automatic test_carry();
        int cyc;
        fill_halt();
        imem[0] = 16'h210F; imem[1] = 16'h2201; imem[2] = 16'h6002; imem[3] = 16'h0312;
        imem[4] = 16'h1412; imem[5] = 16'h3516; imem[6] = 16'hF000;
        start();
        run_to_halt(200, cyc);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL carry_timeout: got halted=%b want 1", halted); end
        checks++; if (dut.rf_q[3] !== 16'h0000 || adder_carry_out !== 1'b1) begin errors++; $display("FAIL carry_add: got r3=%h c=%b want 0000/1", dut.rf_q[3], adder_carry_out); end
        checks++; if ({zf, cf} !== 2'b01) begin errors++; $display("FAIL carry_flags_kept: got zf,cf=%b want 01", {zf, cf}); end
        checks++; if (dut.rf_q[4] !== 16'h0001 || dut.rf_q[5] !== 16'h0006) begin errors++; $display("FAIL carry_and: got %h/%h want 0001/0006", dut.rf_q[4], dut.rf_q[5]); end
    endtask

    task automatic test_mem();
        int cyc;
        fill_halt();
        imem[0] = 16'h210D; imem[1] = 16'h5120; imem[2] = 16'h4420; imem[3] = 16'hF000;
        dmem_wait = 3;
        start();
        run_to_halt(200, cyc);
        dmem_wait = 0;
        checks++; if (halted !== 1'b1 || cyc != 24) begin errors++; $display("FAIL mem_cycles: got halted=%b cycle=%0d want 1 at 24", halted, cyc); end
        checks++; if (wr_count != 1 || dmem[12'h020] !== 16'hFFFD) begin errors++; $display("FAIL mem_write: got count=%0d data=%h want 1/FFFD", wr_count, dmem[12'h020]); end
        checks++; if (st_cycles != 4) begin errors++; $display("FAIL mem_st_req_cycles: got %0d want 4", st_cycles); end
        checks++; if (d_unstable !== 1'b0 || we_bad !== 1'b0) begin errors++; $display("FAIL mem_stable: got unstable=%b we_bad=%b want 0/0", d_unstable, we_bad); end
        checks++; if (dut.rf_q[4] !== 16'hFFFD) begin errors++; $display("FAIL mem_ld: got %h want FFFD", dut.rf_q[4]); end
    endtask

    task automatic test_branch();
        int cyc;
        // JB after CMP 2 vs 7: taken
        fill_halt();
        imem[0] = 16'h2102; imem[1] = 16'h2207; imem[2] = 16'h6012; imem[3] = 16'h9100;
        imem[4] = 16'h2501; imem[5] = 16'hF000;
        start();
        run_to_halt(200, cyc);
        checks++; if ({zf, cf} !== 2'b01) begin errors++; $display("FAIL jb_flags: got zf,cf=%b want 01", {zf, cf}); end
        checks++; if (fetch_log.size() < 5 || fetch_log[4] !== 12'h100) begin errors++; $display("FAIL jb_target: got n=%0d pc=%h want fetch 5 at 100", fetch_log.size(), pc); end
        checks++; if (pc !== 12'h100 || dut.rf_q[5] !== 16'h0) begin errors++; $display("FAIL jb_skip: got pc=%h r5=%h want 100/0000", pc, dut.rf_q[5]); end
        // JA with cf set: not taken
        imem[3] = 16'hA100;
        start();
        run_to_halt(200, cyc);
        checks++; if (fetch_log.size() < 5 || fetch_log[4] !== 12'h004) begin errors++; $display("FAIL ja_fallthru: got n=%0d pc=%h want fetch 5 at 004", fetch_log.size(), pc); end
        checks++; if (pc !== 12'h005 || dut.rf_q[5] !== 16'h1) begin errors++; $display("FAIL ja_result: got pc=%h r5=%h want 005/0001", pc, dut.rf_q[5]); end
        // JE after CMP equal: taken
        imem[2] = 16'h6011; imem[3] = 16'h8100;
        start();
        run_to_halt(200, cyc);
        checks++; if ({zf, cf} !== 2'b10 || pc !== 12'h100) begin errors++; $display("FAIL je_taken: got zf,cf=%b pc=%h want 10/100", {zf, cf}, pc); end
    endtask

    task automatic test_reset_mid();
        fill_halt();
        imem[0] = 16'h2105;
        imem_wait = 0;
        start();
        repeat (4) begin @(posedge clk); #1; end
        imem_wait = 100;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h001 || dut.rf_q[1] !== 16'd5) begin errors++; $display("FAIL mid_pre: got req=%b addr=%h r1=%h want 1/001/0005", imem_req, imem_addr, dut.rf_q[1]); end
        @(negedge clk); #1 reset_n = 0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req_drop: got %b want 0", imem_req); end
        checks++; if (dut.rf_q[1] !== 16'd0 || pc !== 12'h000) begin errors++; $display("FAIL mid_clear: got r1=%h pc=%h want 0000/000", dut.rf_q[1], pc); end
        imem_wait = 0;
        @(posedge clk); #1 reset_n = 1;
        @(negedge clk); #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin errors++; $display("FAIL mid_refetch: got req=%b addr=%h want 1/000", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        fill_halt();
        imem[0] = 16'h7FFF; imem[12'hFFF] = 16'hB000;
        start();
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (pc !== 12'hFFF) begin errors++; $display("FAIL wrap_jmp: got pc=%h want FFF", pc); end
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (pc !== 12'h000) begin errors++; $display("FAIL wrap_pc: got pc=%h want 000", pc); end
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (fetch_log.size() < 3 || fetch_log[1] !== 12'hFFF || fetch_log[2] !== 12'h000) begin errors++; $display("FAIL wrap_fetch: got n=%0d want fetches 000,FFF,000", fetch_log.size()); end
    endtask

    initial begin
        reset_n = 0;
        test_reset();
        test_basic();
        test_carry();
        test_mem();
        test_branch();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
